// File: rtl/rgb_pwm_pkg.sv
// Shared constants and types for the RGB PWM output stage.
// Channel bit positions match the colour word from the pattern generator.
package rgb_pwm_pkg;

    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

    localparam int DEF_PWM_BITS = 8;
    localparam int DEF_PRESC    = 256;
    localparam int DEF_FADE_DIV = 4;

    typedef logic [DEF_PWM_BITS-1:0] pwm_level_t;

endpackage

// File: rtl/rgb_pwm_channel.sv
// One LED channel: latches its target at period boundaries, snaps or ramps its level, registers the PWM compare.
// Latency: LED follows pwm_cnt by 1 clock; no backpressure, output is driven every clock.
module rgb_pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                bnd,
    input  logic                fstep,
    input  logic                fade_en,
    input  logic                rgb_on,
    input  logic [PWM_BITS-1:0] bright,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                busy
);

    logic [PWM_BITS-1:0] tgt;
    logic [PWM_BITS-1:0] lvl;

    // The level update uses the target held before this boundary, so a new colour lags one period.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tgt <= '0;
            lvl <= '0;
            led <= 1'b0;
        end else begin
            led <= (pwm_cnt < lvl);
            if (bnd) begin
                tgt <= rgb_on ? bright : '0;
                if (!fade_en) begin
                    lvl <= tgt;
                end else if (fstep) begin
                    if (lvl < tgt) begin
                        lvl <= lvl + PWM_BITS'(1);
                    end else if (lvl > tgt) begin
                        lvl <= lvl - PWM_BITS'(1);
                    end
                end
            end
        end
    end

    assign busy = (lvl != tgt);

endmodule

// File: rtl/rgb_pwm_driver.sv
// Per-channel PWM drive for an RGB LED with global brightness and optional linear cross-fade.
// Latency: duty changes apply at period boundaries; LED_PWM is registered, 1 clock behind the PWM counter.
module rgb_pwm_driver
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int PRESC    = DEF_PRESC,
    parameter int FADE_DIV = DEF_FADE_DIV
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [2:0]          RGB_IN,
    input  logic [PWM_BITS-1:0] BRIGHT,
    input  logic                FADE_EN,
    output logic [2:0]          LED_PWM,
    output logic                BUSY
);

    localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int FADE_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    logic [PRESC_W-1:0]  presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [FADE_W-1:0]   fcnt;
    logic                tick;
    logic                bnd;
    logic                fstep;
    logic [2:0]          ch_busy;

    assign tick  = (presc == PRESC_W'(PRESC - 1));
    assign bnd   = tick && (&pwm_cnt);
    assign fstep = bnd && (fcnt == FADE_W'(FADE_DIV - 1));

    // fcnt runs regardless of FADE_EN so enabling fade never realigns the step cadence.
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc   <= '0;
            pwm_cnt <= '0;
            fcnt    <= '0;
        end else begin
            presc <= tick ? '0 : presc + PRESC_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
            if (bnd) begin
                fcnt <= (fcnt == FADE_W'(FADE_DIV - 1)) ? '0 : fcnt + FADE_W'(1);
            end
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_ch
        rgb_pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .CLK    (CLK),
            .RST    (RST),
            .bnd    (bnd),
            .fstep  (fstep),
            .fade_en(FADE_EN),
            .rgb_on (RGB_IN[c]),
            .bright (BRIGHT),
            .pwm_cnt(pwm_cnt),
            .led    (LED_PWM[c]),
            .busy   (ch_busy[c])
        );
    end

    assign BUSY = |ch_busy;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: edge-count reference model feeds a scoreboard queue, a monitor compares every clock.
module tb_rgb_pwm_driver;
    import rgb_pwm_pkg::*;

    localparam int PWM_BITS = 4;
    localparam int PRESC    = 1;
    localparam int FADE_DIV = 2;
    localparam int PERIOD   = 1 << PWM_BITS;

    typedef struct packed {
        logic [2:0] led;
        logic       busy;
    } exp_t;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [2:0]          RGB_IN = 3'b111;
    logic [PWM_BITS-1:0] BRIGHT = 4'd15;
    logic                FADE_EN = 1'b0;
    logic [2:0]          LED_PWM;
    logic                BUSY;

    int   checks = 0;
    int   errors = 0;
    int   shown  = 0;
    bit   running = 1'b1;
    exp_t exp_q[$];

    int m_e;
    int m_tgt[3];
    int m_lvl[3];

    rgb_pwm_driver #(
        .PWM_BITS(PWM_BITS),
        .PRESC   (PRESC),
        .FADE_DIV(FADE_DIV)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .RGB_IN (RGB_IN),
        .BRIGHT (BRIGHT),
        .FADE_EN(FADE_EN),
        .LED_PWM(LED_PWM),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    // Reference: the position in the PWM period and the boundary index follow from the edge count alone.
    always @(posedge CLK) begin
        exp_t x;
        int   cnt;
        int   b;
        bit   is_bnd;
        bit   is_step;
        int   newt;
        x = '0;
        if (RST) begin
            m_e = 0;
            for (int c = 0; c < 3; c++) begin
                m_tgt[c] = 0;
                m_lvl[c] = 0;
            end
        end else begin
            cnt    = (m_e / PRESC) % PERIOD;
            is_bnd = ((m_e % PRESC) == PRESC - 1) && (cnt == PERIOD - 1);
            for (int c = 0; c < 3; c++) x.led[c] = (cnt < m_lvl[c]);
            if (is_bnd) begin
                b       = (m_e / PRESC) / PERIOD;
                is_step = ((b % FADE_DIV) == FADE_DIV - 1);
                for (int c = 0; c < 3; c++) begin
                    newt = RGB_IN[c] ? int'(BRIGHT) : 0;
                    if (!FADE_EN)                   m_lvl[c] = m_tgt[c];
                    else if (is_step && m_lvl[c] < m_tgt[c]) m_lvl[c] = m_lvl[c] + 1;
                    else if (is_step && m_lvl[c] > m_tgt[c]) m_lvl[c] = m_lvl[c] - 1;
                    m_tgt[c] = newt;
                end
            end
            m_e = m_e + 1;
            for (int c = 0; c < 3; c++) x.busy |= (m_lvl[c] != m_tgt[c]);
        end
        exp_q.push_back(x);
    end

    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (running) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (LED_PWM !== e.led || BUSY !== e.busy) begin
                    errors++;
                    if (shown < 20) begin
                        shown++;
                        $display("FAIL outputs t=%0t LED_PWM=%b BUSY=%b expected LED_PWM=%b BUSY=%b",
                                 $time, LED_PWM, BUSY, e.led, e.busy);
                    end
                end
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic duty_check(input string name, input int ch, input int want);
        int hi;
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge CLK);
            hi += int'(LED_PWM[ch]);
        end
        checks++;
        if (hi != want) begin
            errors++;
            $display("FAIL %s ch=%0d high_clocks=%0d expected=%0d", name, ch, hi, want);
        end
    endtask

    task automatic wait_lvl_g(input string name, input int want);
        int i;
        for (i = 0; i < 2000 && m_lvl[CH_G] != want; i++) @(negedge CLK);
        checks++;
        if (m_lvl[CH_G] != want) begin
            errors++;
            $display("FAIL %s timeout model_lvl=%0d expected=%0d", name, m_lvl[CH_G], want);
        end
    endtask

    initial begin
        // Reset held with everything requested on: outputs must stay dark.
        run(3);
        RST = 1'b0;

        // Snap mode, red at duty 4/16.
        BRIGHT = 4'd4;
        RGB_IN = 3'b100;
        run(3 * PERIOD);
        duty_check("snap_red", CH_R, 4);
        duty_check("snap_green_off", CH_G, 0);
        duty_check("snap_blue_off", CH_B, 0);

        // Duty extremes.
        BRIGHT = 4'd15;
        run(3 * PERIOD);
        duty_check("duty_max", CH_R, 15);
        BRIGHT = 4'd0;
        run(3 * PERIOD);
        duty_check("duty_zero", CH_R, 0);

        // Fade up green, reverse at level 4.
        FADE_EN = 1'b1;
        BRIGHT  = 4'd8;
        RGB_IN  = 3'b000;
        run(3 * PERIOD);
        RGB_IN = 3'b010;
        wait_lvl_g("fade_up_to_4", 4);
        RGB_IN = 3'b000;
        wait_lvl_g("fade_down_to_0", 0);
        run(3 * PERIOD);

        // Full ramp, then reset mid-fade at level 5.
        RGB_IN = 3'b010;
        wait_lvl_g("fade_up_to_5", 5);
        RST = 1'b1;
        run(1);
        RST = 1'b0;
        wait_lvl_g("ramp_after_reset", 8);
        run(4 * PERIOD);

        // Randomised colour, brightness, fade and occasional reset.
        for (int k = 0; k < 60; k++) begin
            RGB_IN  = 3'($urandom_range(0, 7));
            BRIGHT  = 4'($urandom_range(0, 15));
            FADE_EN = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                RST = 1'b1;
                run(int'($urandom_range(1, 3)));
                RST = 1'b0;
            end
            run(int'($urandom_range(1, 6 * PERIOD)));
        end

        run(2);
        running = 1'b0;
        @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
